// File: rtl/async_req_arbiter.sv
// Four-requester round-robin arbiter fed by asynchronous request lines.
// Each request is synchronized through two flops, then a three-state FSM
// (IDLE -> GRANT -> RELEASE -> IDLE) hands out a registered one-hot grant.
// Define ARB_TIMEOUT_EN to compile in the grant watchdog: a grant held for
// MAX_HOLD cycles is revoked, timeout pulses, and the requester stays masked
// until its request drops.
module async_req_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] async_req,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  state_e     state_q, state_d;
  logic [3:0] req_meta_q, req_s_q;
  logic [3:0] grant_q, grant_d;
  logic [1:0] grant_id_q, grant_id_d;
  logic [1:0] last_id_q, last_id_d;
  logic [3:0] eligible;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;

  if (MAX_HOLD < 2) begin : g_hold_chk
    $error("MAX_HOLD must be at least 2");
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(MAX_HOLD);

  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]      mask_q, mask_d;
  logic            timeout_q, timeout_d;

  assign eligible = req_s_q & ~mask_q;
  assign timeout  = timeout_q;
`else
  assign eligible = req_s_q;
  assign timeout  = 1'b0;
`endif

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q != StIdle);

  // Two-flop synchronizer per request line.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      req_meta_q <= '0;
      req_s_q    <= '0;
    end else begin
      req_meta_q <= async_req;
      req_s_q    <= req_meta_q;
    end
  end

  // Round-robin search: first eligible index upward from last_id+1, wrapping.
  always_comb begin
    winner = last_id_q + 2'd1;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_id_q + 2'(i);
      if (!found && eligible[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    // A mask bit lives only as long as its request stays high.
    mask_d     = mask_q & req_s_q;
`endif
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d    = StGrant;
          grant_d    = 4'b0001 << winner;
          grant_id_d = winner;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      StGrant: begin
        if (!req_s_q[grant_id_q]) begin
          state_d   = StRelease;
          grant_d   = '0;
          last_id_d = grant_id_q;
`ifdef ARB_TIMEOUT_EN
        end else if (hold_cnt_q == CntW'(MAX_HOLD - 1)) begin
          state_d             = StRelease;
          grant_d             = '0;
          last_id_d           = grant_id_q;
          timeout_d           = 1'b1;
          mask_d[grant_id_q]  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
`endif
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM and grant state; reset drops grant immediately, skipping RELEASE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      grant_id_q <= '0;
      // last_id of 3 makes the first search start at requester 0.
      last_id_q  <= 2'd3;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Watchdog state: hold counter, per-requester mask, timeout pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_cnt_q <= '0;
      mask_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      mask_q     <= mask_d;
      timeout_q  <= timeout_d;
    end
  end
`endif

endmodule

// File: tb/tb_async_req_arbiter.sv
// Self-checking bench for async_req_arbiter: directed scenarios plus random
// request traffic compared cycle by cycle against a behavioural model.
// Honours ARB_TIMEOUT_EN the same way the design does.
module tb_async_req_arbiter;

  localparam int unsigned MaxHold = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [3:0] async_req = 4'b0000;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int passed = 0;

  async_req_arbiter #(.MAX_HOLD(MaxHold)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .async_req(async_req),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural model: phase 0 idle, 1 granted, 2 release.
  logic [3:0] m_s1, m_s2, m_block;
  int         m_phase, m_owner, m_last, m_gid, m_held;
  bit         m_to;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_block = '0;
    m_phase = 0; m_owner = 0; m_last = 3; m_gid = 0; m_held = 0; m_to = 0;
  endtask

  task automatic model_step();
    logic [3:0] elig;
    logic [3:0] nblock;
    bit         hit;
    elig   = m_s2 & ~m_block;
    nblock = m_block & m_s2;
    m_to   = 0;
    hit    = 0;
    case (m_phase)
      0: begin
        for (int k = 1; k <= 4; k++) begin
          if (!hit && elig[(m_last + k) % 4]) begin
            m_owner = (m_last + k) % 4;
            hit = 1;
          end
        end
        if (hit) begin
          m_gid = m_owner; m_phase = 1; m_held = 0;
        end
      end
      1: begin
        if (!m_s2[m_owner]) begin
          m_phase = 2; m_last = m_owner;
        end else if (TimeoutOn && m_held == int'(MaxHold) - 1) begin
          m_phase = 2; m_last = m_owner; nblock[m_owner] = 1'b1; m_to = 1;
        end else begin
          m_held++;
        end
      end
      default: m_phase = 0;
    endcase
    m_block = nblock;
    m_s2 = m_s1;
    m_s1 = async_req;
  endtask

  function automatic logic [3:0] exp_grant();
    return (m_phase == 1) ? (4'b0001 << m_owner) : 4'b0000;
  endfunction

  // Advance one clock, step the model, and land 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    if (n_rst) model_step();
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    async_req = 4'b0000;
    model_reset();
    tick();
    checks++;
    if (grant !== 4'b0000 || grant_id !== 2'd0 || busy !== 1'b0 || timeout !== 1'b0)
      $display("FAIL reset_state: grant=%b id=%0d busy=%b timeout=%b want 0000/0/0/0",
               grant, grant_id, busy, timeout);
    else passed++;
    #3 n_rst = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0)
      $display("FAIL post_reset_idle: grant=%b busy=%b want 0000/0", grant, busy);
    else passed++;
  endtask

  task automatic test_single();
    test_reset();
    async_req = 4'b0001;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (grant !== ((c == 3) ? 4'b0001 : 4'b0000))
        $display("FAIL single_latency: edge %0d grant=%b want %b", c, grant,
                 (c == 3) ? 4'b0001 : 4'b0000);
      else passed++;
      checks++;
      if (grant !== exp_grant())
        $display("FAIL single_model: edge %0d grant=%b model %b", c, grant, exp_grant());
      else passed++;
    end
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd0)
      $display("FAIL single_busy_id: busy=%b id=%0d want 1/0", busy, grant_id);
    else passed++;
    async_req = 4'b0000;
    repeat (6) tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [5];
    logic [3:0] prev;
    int ngr, age, rel;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
    seq[4] = 4'b0001;
    test_reset();
    async_req = 4'b1111;
    prev = '0; ngr = 0; age = 0; rel = 0;
    for (int n = 0; n < 200 && ngr < 5; n++) begin
      tick();
      checks++;
      if (grant !== exp_grant())
        $display("FAIL rr_model: cycle %0d grant=%b model %b", n, grant, exp_grant());
      else passed++;
      if (grant != 4'b0000 && grant != prev) begin
        checks++;
        if (grant !== seq[ngr])
          $display("FAIL rr_order: grant #%0d=%b want %b", ngr, grant, seq[ngr]);
        else passed++;
        if (ngr > 0) begin
          checks++;
          if (rel != 1)
            $display("FAIL rr_release_gap: release cycles=%0d want 1", rel);
          else passed++;
        end
        ngr++; age = 0; rel = 0;
      end
      if (grant == 4'b0000 && busy) rel++;
      if (grant != 4'b0000) begin
        age++;
        if (age == 4) async_req[grant_id] = 1'b0;
      end else begin
        async_req = 4'b1111;
      end
      prev = grant;
    end
    checks++;
    if (ngr != 5) $display("FAIL rr_count: grants=%0d want 5", ngr);
    else passed++;
    async_req = 4'b0000;
    repeat (12) tick();
  endtask

  task automatic test_search_start();
    int n;
    test_reset();
    async_req = 4'b0100;
    n = 0;
    while (grant !== 4'b0100 && n < 10) begin tick(); n++; end
    checks++;
    if (grant !== 4'b0100) $display("FAIL ss_first: grant=%b want 0100", grant);
    else passed++;
    async_req = 4'b1011;
    n = 0;
    do begin
      tick(); n++;
      checks++;
      if (grant !== exp_grant())
        $display("FAIL ss_model: grant=%b model %b", grant, exp_grant());
      else passed++;
    end while ((grant == 4'b0000 || grant == 4'b0100) && n < 20);
    checks++;
    if (grant !== 4'b1000 || grant_id !== 2'd3)
      $display("FAIL ss_next: grant=%b id=%0d want 1000/3", grant, grant_id);
    else passed++;
    async_req = 4'b0000;
    repeat (6) tick();
  endtask

  task automatic test_reset_mid_grant();
    int n;
    async_req = 4'b0100;
    n = 0;
    while (grant !== 4'b0100 && n < 12) begin tick(); n++; end
    checks++;
    if (grant !== 4'b0100) $display("FAIL rmg_setup: grant=%b want 0100", grant);
    else passed++;
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd0)
      $display("FAIL rmg_async_clear: grant=%b busy=%b id=%0d want 0000/0/0",
               grant, busy, grant_id);
    else passed++;
    model_reset();
    #2 n_rst = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (grant !== ((c == 3) ? 4'b0100 : 4'b0000))
        $display("FAIL rmg_regrant: edge %0d grant=%b want %b", c, grant,
                 (c == 3) ? 4'b0100 : 4'b0000);
      else passed++;
    end
    async_req = 4'b0000;
    repeat (6) tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n, held;
    test_reset();
    async_req = 4'b0011;
    n = 0;
    while (grant !== 4'b0001 && n < 10) begin tick(); n++; end
    held = 0;
    while (grant === 4'b0001 && held < 40) begin held++; tick(); end
    checks++;
    if (held != int'(MaxHold)) $display("FAIL to_hold: cycles=%0d want %0d", held, MaxHold);
    else passed++;
    checks++;
    if (timeout !== 1'b1 || grant !== 4'b0000 || busy !== 1'b1)
      $display("FAIL to_pulse: timeout=%b grant=%b busy=%b want 1/0000/1",
               timeout, grant, busy);
    else passed++;
    tick();
    checks++;
    if (timeout !== 1'b0 || grant !== 4'b0000)
      $display("FAIL to_release: timeout=%b grant=%b want 0/0000", timeout, grant);
    else passed++;
    tick();
    checks++;
    if (grant !== 4'b0010) $display("FAIL to_next: grant=%b want 0010", grant);
    else passed++;
    async_req = 4'b0001;
    repeat (10) tick();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0)
      $display("FAIL to_masked: grant=%b busy=%b want 0000/0", grant, busy);
    else passed++;
    async_req = 4'b0000;
    repeat (3) tick();
    async_req = 4'b0001;
    n = 0;
    while (grant !== 4'b0001 && n < 8) begin tick(); n++; end
    checks++;
    if (grant !== 4'b0001) $display("FAIL to_unmask: grant=%b want 0001", grant);
    else passed++;
    async_req = 4'b0000;
    repeat (6) tick();
  endtask
`endif

  task automatic test_random();
    test_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) async_req[$urandom_range(0, 3)] ^= 1'b1;
      tick();
      checks++;
      if (grant !== exp_grant())
        $display("FAIL rnd_grant: cycle %0d grant=%b model %b", n, grant, exp_grant());
      else passed++;
      checks++;
      if (grant_id !== 2'(m_gid))
        $display("FAIL rnd_id: cycle %0d id=%0d model %0d", n, grant_id, m_gid);
      else passed++;
      checks++;
      if (busy !== (m_phase != 0))
        $display("FAIL rnd_busy: cycle %0d busy=%b model %b", n, busy, m_phase != 0);
      else passed++;
      checks++;
      if (timeout !== m_to)
        $display("FAIL rnd_timeout: cycle %0d timeout=%b model %b", n, timeout, m_to);
      else passed++;
      checks++;
      if ($countones(grant) > 1)
        $display("FAIL rnd_onehot: cycle %0d grant=%b want at most one bit", n, grant);
      else passed++;
    end
    async_req = 4'b0000;
    repeat (8) tick();
  endtask

  task automatic test_glitch();
    int high;
    test_reset();
    // 3-unit pulse straddling a rising edge so the first flop captures it.
    #7 async_req[1] = 1'b1;
    #3 async_req[1] = 1'b0;
    high = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      checks++;
      if (grant !== 4'b0000 && grant !== 4'b0010)
        $display("FAIL glitch_grant: cycle %0d grant=%b want 0000 or 0010", n, grant);
      else passed++;
      if (grant == 4'b0010) high++;
    end
    checks++;
    if (high > 4 || grant !== 4'b0000)
      $display("FAIL glitch_release: high cycles=%0d final=%b want <=4/0000", high, grant);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_search_start();
    test_reset_mid_grant();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    test_glitch();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
